// File: rtl/scl_bit_counter_pkg.sv
// Shared types and defaults for the SCL bit counter.
// Used by all scl_bit_counter files; optional feature macro: SCL_BITCNT_ERR_EN.
package scl_bitcnt_pkg;

    typedef enum logic [1:0] {
        MODE_SDR    = 2'd0,
        MODE_DDR    = 2'd1,
        MODE_CUSTOM = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    localparam int unsigned SDR_LEN_DEF = 9;
    localparam int unsigned DDR_LEN_DEF = 20;
    localparam int unsigned MIN_LEN     = 2;

    // Reserved mode falls back to SDR; custom frames shorter than MIN_LEN are clamped.
    function automatic int unsigned eff_len(input mode_e       mode,
                                            input int unsigned frame_len,
                                            input int unsigned sdr_len = SDR_LEN_DEF,
                                            input int unsigned ddr_len = DDR_LEN_DEF);
        case (mode)
            MODE_DDR:    return ddr_len;
            MODE_CUSTOM: return (frame_len < MIN_LEN) ? MIN_LEN : frame_len;
            default:     return sdr_len;
        endcase
    endfunction

endpackage

// File: rtl/scl_bit_counter_if.sv
// Control/status bundle between the controller FSM, data paths and the bit counter.
// o_edge_err exists only when SCL_BITCNT_ERR_EN is defined.
interface scl_bit_counter_if #(
    parameter int CNT_W  = 5,
    parameter int FCNT_W = 8
);
    logic              i_bitcnt_en;
    logic              i_scl_pos_edge;
    logic              i_scl_neg_edge;
    logic [1:0]        i_mode;
    logic [CNT_W-1:0]  i_frame_len;
    logic [CNT_W-1:0]  o_cnt_bit_count;
    logic              o_last_bit;
    logic              o_parity_window;
    logic              o_frame_done;
    logic [FCNT_W-1:0] o_frame_cnt;
    logic              o_abort;
    logic              o_busy;
`ifdef SCL_BITCNT_ERR_EN
    logic              o_edge_err;
`endif

    modport slave (
`ifdef SCL_BITCNT_ERR_EN
        output o_edge_err,
`endif
        input  i_bitcnt_en, i_scl_pos_edge, i_scl_neg_edge, i_mode, i_frame_len,
        output o_cnt_bit_count, o_last_bit, o_parity_window, o_frame_done,
               o_frame_cnt, o_abort, o_busy
    );

    modport master (
`ifdef SCL_BITCNT_ERR_EN
        input  o_edge_err,
`endif
        output i_bitcnt_en, i_scl_pos_edge, i_scl_neg_edge, i_mode, i_frame_len,
        input  o_cnt_bit_count, o_last_bit, o_parity_window, o_frame_done,
               o_frame_cnt, o_abort, o_busy
    );

endinterface

// File: rtl/scl_bit_counter_edge_qual.sv
// scl_edge_qual: picks the SCL strobe(s) that advance the count for the latched mode.
// With SCL_BITCNT_ERR_EN defined, also flags coincident or too-closely spaced strobes.
module scl_edge_qual
    import scl_bitcnt_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_latch,
    input  logic [1:0] i_mode,
    input  logic       i_active,
    input  logic       i_pos,
    input  logic       i_neg,
`ifdef SCL_BITCNT_ERR_EN
    input  logic       i_frame_done,
    output logic       o_edge_err,
`endif
    output logic       o_qual
);

    logic r_ddr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ddr <= 1'b0;
        end else if (i_latch) begin
            r_ddr <= (mode_e'(i_mode) == MODE_DDR);
        end
    end

    // Coincident pos/neg strobes collapse into a single edge.
    assign o_qual = i_active && (i_neg || (r_ddr && i_pos));

`ifdef SCL_BITCNT_ERR_EN
    logic r_edge_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_edge_err <= 1'b0;
        end else begin
            r_edge_err <= i_active && ((i_pos && i_neg) || (o_qual && i_frame_done));
        end
    end

    assign o_edge_err = r_edge_err;
`endif

endmodule

// File: rtl/scl_bit_counter.sv
// SCL bit-period counter for SDR, HDR-DDR and custom-length I3C frames.
// Optional strobe error output enabled by defining SCL_BITCNT_ERR_EN.
module scl_bit_counter
    import scl_bitcnt_pkg::*;
#(
    parameter int          CNT_W   = 5,
    parameter int unsigned SDR_LEN = SDR_LEN_DEF,
    parameter int unsigned DDR_LEN = DDR_LEN_DEF,
    parameter int          FCNT_W  = 8
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    scl_bit_counter_if.slave  bus
);

    state_e            r_state,    w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
    logic [CNT_W-1:0]  r_last_idx, w_last_idx_nxt;
    logic [CNT_W-1:0]  r_par_idx,  w_par_idx_nxt;
    logic [FCNT_W-1:0] r_fcnt,     w_fcnt_nxt;
    logic              r_done,     w_done_nxt;
    logic              r_abort,    w_abort_nxt;

    logic              w_latch;
    logic              w_active;
    logic              w_qual;
    mode_e             w_mode;
    int unsigned       w_len;

    assign w_latch  = (r_state == ST_IDLE)  && bus.i_bitcnt_en;
    assign w_active = (r_state == ST_COUNT) && bus.i_bitcnt_en;
    assign w_mode   = mode_e'(bus.i_mode);
    assign w_len    = eff_len(w_mode, 32'(bus.i_frame_len), SDR_LEN, DDR_LEN);

    scl_edge_qual u_edge_qual (
        .i_clk        (i_sys_clk),
        .i_rst        (i_rst),
        .i_latch      (w_latch),
        .i_mode       (bus.i_mode),
        .i_active     (w_active),
        .i_pos        (bus.i_scl_pos_edge),
        .i_neg        (bus.i_scl_neg_edge),
`ifdef SCL_BITCNT_ERR_EN
        .i_frame_done (r_done),
        .o_edge_err   (bus.o_edge_err),
`endif
        .o_qual       (w_qual)
    );

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last_idx <= '0;
            r_par_idx  <= '0;
            r_fcnt     <= '0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_par_idx  <= w_par_idx_nxt;
            r_fcnt     <= w_fcnt_nxt;
            r_done     <= w_done_nxt;
            r_abort    <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_last_idx_nxt = r_last_idx;
        w_par_idx_nxt  = r_par_idx;
        w_fcnt_nxt     = r_fcnt;
        w_done_nxt     = 1'b0;
        w_abort_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.i_bitcnt_en) begin
                    // Frame geometry is frozen here for the whole enable period.
                    w_state_nxt    = ST_COUNT;
                    w_fcnt_nxt     = '0;
                    w_last_idx_nxt = CNT_W'(w_len - 1);
                    w_par_idx_nxt  = (w_mode == MODE_DDR) ? CNT_W'(w_len - 2)
                                                          : CNT_W'(w_len - 1);
                end
            end
            ST_COUNT: begin
                if (!bus.i_bitcnt_en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_abort_nxt = (r_cnt != '0);
                end else if (w_qual) begin
                    if (r_cnt == r_last_idx) begin
                        w_cnt_nxt  = '0;
                        w_done_nxt = 1'b1;
                        w_fcnt_nxt = r_fcnt + FCNT_W'(1);
                    end else begin
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.o_cnt_bit_count = r_cnt;
    assign bus.o_last_bit      = (r_state == ST_COUNT) && (r_cnt == r_last_idx);
    assign bus.o_parity_window = (r_state == ST_COUNT) && (r_cnt >= r_par_idx);
    assign bus.o_frame_done    = r_done;
    assign bus.o_frame_cnt     = r_fcnt;
    assign bus.o_abort         = r_abort;
    assign bus.o_busy          = (r_state == ST_COUNT);

endmodule

// File: tb/tb_scl_bit_counter.sv
// Scoreboard bench for scl_bit_counter: a frame-level model predicts every cycle's outputs.
// Checks o_edge_err as well when built with SCL_BITCNT_ERR_EN.
module tb_scl_bit_counter;
    import scl_bitcnt_pkg::*;

    localparam int CNT_W  = 5;
    localparam int FCNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scl_bit_counter_if #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) bus ();

    scl_bit_counter #(
        .CNT_W(CNT_W), .SDR_LEN(9), .DDR_LEN(20), .FCNT_W(FCNT_W)
    ) dut (
        .i_sys_clk (clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    typedef struct {
        int cnt;
        int fcnt;
        bit last;
        bit par;
        bit done;
        bit abort;
        bit busy;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Stimulus settings held between cycles
    bit cur_rst  = 1'b1;
    bit cur_en   = 1'b0;
    int cur_mode = 0;
    int cur_flen = 0;

    // Reference model: position within the frame and frames completed.
    bit m_on        = 1'b0;
    int m_bit       = 0;
    int m_len       = 0;
    bit m_ddr       = 1'b0;
    int m_frames    = 0;
    bit m_done_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit pos, input bit neg);
        exp_t e;
        bit   edge_q;
        @(negedge clk);
        #1;
        rst                = cur_rst;
        bus.i_bitcnt_en    = cur_en;
        bus.i_scl_pos_edge = pos;
        bus.i_scl_neg_edge = neg;
        bus.i_mode         = 2'(cur_mode);
        bus.i_frame_len    = CNT_W'(cur_flen);

        e = '{cnt: 0, fcnt: 0, last: 0, par: 0, done: 0, abort: 0, busy: 0, err: 0};
        if (cur_rst) begin
            m_on = 0; m_bit = 0; m_frames = 0; m_len = 0; m_ddr = 0;
        end else if (!m_on) begin
            m_bit = 0;
            if (cur_en) begin
                m_on     = 1;
                m_frames = 0;
                m_ddr    = (cur_mode == 1);
                case (cur_mode)
                    1:       m_len = 20;
                    2:       m_len = (cur_flen < 2) ? 2 : cur_flen;
                    default: m_len = 9;
                endcase
            end
        end else if (!cur_en) begin
            e.abort = (m_bit != 0);
            m_bit   = 0;
            m_on    = 0;
        end else begin
            edge_q = neg || (m_ddr && pos);
            e.err  = (pos && neg) || (edge_q && m_done_prev);
            if (edge_q) begin
                m_bit = (m_bit + 1) % m_len;
                if (m_bit == 0) begin
                    e.done   = 1;
                    m_frames = (m_frames + 1) % 256;
                end
            end
        end
        e.cnt  = m_bit;
        e.fcnt = m_frames;
        e.busy = m_on;
        e.last = m_on && (m_bit == m_len - 1);
        e.par  = m_on && (m_ddr ? (m_bit >= m_len - 2) : (m_bit == m_len - 1));
        m_done_prev = e.done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    // Monitor: compares the DUT against the oldest prediction every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("bit_count",     int'(bus.o_cnt_bit_count), e.cnt);
                chk("frame_cnt",     int'(bus.o_frame_cnt),     e.fcnt);
                chk("last_bit",      int'(bus.o_last_bit),      int'(e.last));
                chk("parity_window", int'(bus.o_parity_window), int'(e.par));
                chk("frame_done",    int'(bus.o_frame_done),    int'(e.done));
                chk("abort",         int'(bus.o_abort),         int'(e.abort));
                chk("busy",          int'(bus.o_busy),          int'(e.busy));
`ifdef SCL_BITCNT_ERR_EN
                chk("edge_err",      int'(bus.o_edge_err),      int'(e.err));
`endif
            end
        end
    end

    initial begin
        bus.i_bitcnt_en    = 1'b0;
        bus.i_scl_pos_edge = 1'b0;
        bus.i_scl_neg_edge = 1'b0;
        bus.i_mode         = 2'd0;
        bus.i_frame_len    = '0;

        cur_rst = 1; idle(3); cur_rst = 0; idle(2);

        // SDR frame: posedges interleaved but ignored
        cur_mode = 0; cur_en = 1; idle(2);
        for (int i = 0; i < 9; i++) begin step(1, 0); step(0, 1); step(0, 0); end
        idle(2); cur_en = 0; idle(2);

        // Reset in the middle of a frame
        cur_en = 1; idle(1);
        for (int i = 0; i < 4; i++) begin step(0, 1); step(0, 0); end
        cur_rst = 1; idle(3); cur_rst = 0; cur_en = 0; idle(2);

        // DDR: two words back to back, strobe every cycle
        cur_mode = 1; cur_en = 1; idle(2);
        for (int i = 0; i < 20; i++) begin step(1, 0); step(0, 1); end
        idle(1); cur_en = 0; idle(2);

        // CUSTOM length 5, then length 1 (clamped to 2)
        cur_mode = 2; cur_flen = 5; cur_en = 1; idle(2);
        for (int i = 0; i < 10; i++) begin step(0, 1); step(0, 0); end
        cur_en = 0; idle(2);
        cur_flen = 1; cur_en = 1; idle(2);
        for (int i = 0; i < 6; i++) begin step(0, 1); step(0, 0); end
        cur_en = 0; idle(2);

        // Abort after 4 SDR bits, then en falls on a qualifying edge
        cur_mode = 0; cur_en = 1; idle(2);
        for (int i = 0; i < 4; i++) begin step(0, 1); step(0, 0); end
        cur_en = 0; step(0, 1); idle(2);

        // Mode and length changes while enabled are ignored
        cur_mode = 0; cur_en = 1; idle(2);
        cur_mode = 2; cur_flen = 3;
        for (int i = 0; i < 10; i++) begin step(1, 0); step(0, 1); end
        cur_en = 0; idle(2);

        // Coincident strobes in DDR, including right after a wrap
        cur_mode = 1; cur_en = 1; idle(2);
        step(1, 1); idle(1); step(1, 1); step(0, 1);
        for (int i = 0; i < 17; i++) step(0, 1);
        step(1, 0); step(1, 1); idle(2);
        cur_en = 0; idle(2);

        // Randomized traffic across modes, lengths, aborts and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) cur_rst = 1;
            else cur_rst = 0;
            if ($urandom_range(0, 79) == 0) begin
                cur_en = !cur_en;
                if (cur_en) begin
                    cur_mode = int'($urandom_range(0, 3));
                    cur_flen = int'($urandom_range(0, 31));
                end
            end else if ($urandom_range(0, 29) == 0) begin
                cur_mode = int'($urandom_range(0, 3));
                cur_flen = int'($urandom_range(0, 31));
            end
            step(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 2) == 0));
        end
        cur_rst = 0; cur_en = 0; idle(3);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
